tbman_print_uart: RTL
=====================

// Module: tbman_print_uart
//
// PURPOSE
//   Consumes the print byte stream (print_o/print_wen) from the testbench manager
//   on FPGA builds and transmits it on a UART TX pin. Each write request is a
//   single-cycle byte strobe; an internal FIFO absorbs bursts. The 8N1
//   serialiser drains the FIFO. An optional LF->CRLF expansion gives
//   terminal-friendly output. Sits directly downstream of tbman in the
//   peripheral subsystem.
//
// PARAMETERS
//   CLK_DIV     16  clk cycles per UART bit; legal range >= 2
//   FIFO_DEPTH  16  print FIFO entries; power of 2, >= 2
//   CRLF        1   1: send 0x0D before every 0x0A; 0: bytes sent verbatim
//
// PORTS
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   print_wen  in   1  byte write strobe, one byte per asserted cycle
//   print_o    in   8  byte to print, valid when print_wen=1
//   ovf_clr    in   1  clears the overflow flag
//   tx         out  1  UART serial output, idle high
//   busy       out  1  1 while the FIFO is non-empty or a frame is in flight
//   fifo_full  out  1  FIFO occupancy == FIFO_DEPTH
//   overflow   out  1  sticky: a byte was dropped because the FIFO was full
//
// BEHAVIOUR
//   Reset
//   - All state is cleared asynchronously on rst_n low.
//   - Reset values: tx=1, busy=0, fifo_full=0, overflow=0, FIFO empty, state IDLE.
//   - Reset mid-frame aborts the frame; tx is high from reset assertion onward.
//
//   FIFO
//   - Push when print_wen=1 and (count<FIFO_DEPTH, or a pop occurs in the same cycle).
//   - Otherwise the byte is dropped and overflow<=1.
//   - Simultaneous push and pop leave count unchanged.
//   - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
//   - fifo_full and busy are registered, derived from next-state count and state.
//   - overflow set has priority over ovf_clr in the same cycle.
//
//   State machine: IDLE, START, DATA, STOP. A bit counter and a baud counter
//   (0..CLK_DIV-1) advance each state.
//   - IDLE: if FIFO non-empty, pop, load the shifter, go to START.
//   - START: tx=0 for CLK_DIV cycles, then DATA.
//   - DATA: 8 bits, LSB first, each held for CLK_DIV cycles, then STOP.
//   - STOP: tx=1 for CLK_DIV cycles.
//     - On the last STOP cycle, if a byte is pending or the FIFO is non-empty,
//       load it and go to START (zero idle gap).
//     - Otherwise go to IDLE.
//   - Frame length: exactly 10*CLK_DIV cycles.
//
//   Latency
//   - A byte written at edge N into an empty FIFO with the machine in IDLE
//     drives the start bit on tx from edge N+2.
//
//   CRLF
//   - When CRLF=1 and the popped byte is 0x0A, transmit 0x0D first.
//   - Hold 0x0A in a pending register and send it as the next frame without a
//     further pop. The pending byte takes priority over the FIFO.
//   - The pending byte counts towards busy.
//   - No other byte is altered; 0x0D input is sent verbatim.
//
//   tx is driven from a flop (glitch-free).
//
// TESTING
//   1. Reset: hold rst_n=0 -> tx=1, busy=0, overflow=0, fifo_full=0.
//   2. Single byte, CLK_DIV=4: write 0x55 -> tx low 4 cycles, then
//      1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles; busy drops after
//      40 cycles.
//   3. CRLF=1, write 0x0A -> two back-to-back frames 0x0D then 0x0A, 80 cycles
//      at CLK_DIV=4, no gap. CRLF=0 -> single frame 0x0A.
//   4. Overflow, FIFO_DEPTH=16: write 18 bytes on consecutive cycles from idle
//      -> 17 accepted (first pop frees a slot), byte 18 dropped.
//      - overflow=1 and fifo_full=1 observed.
//      - Transmitted order matches the 17 accepted bytes.
//      - ovf_clr pulse -> overflow=0.
//   5. Back-to-back throughput: write 0x41,0x42,0x43 -> three frames with zero
//      idle cycles; busy continuously 1 for 30*CLK_DIV+1 cycles.
//   6. Reset mid-frame: assert rst_n=0 during DATA of 0x00 -> tx=1 at once.
//      - After release, FIFO empty, no residual frame.
//      - The next write transmits correctly.

Source files
------------

// File: rtl/tbman_print_uart.sv
// Print-stream UART transmitter: a byte FIFO feeding an 8N1 serialiser,
// with optional LF->CRLF expansion. The tx pin is a flop trailing the state machine by one cycle.
module tbman_print_uart #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CRLF       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       print_wen,
    input  logic [7:0] print_o,
    input  logic       ovf_clr,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_n;
    logic [1:0]    state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shifter, shift_n;
    logic          pend, pend_n;
    logic          do_pop, do_push, load;
    logic          tx_n, busy_n;
    logic [7:0]    head;

    assign head = mem[rd_ptr];

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        shift_n = shifter;
        pend_n  = pend;
        do_pop  = 1'b0;
        load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    do_pop = 1'b1;
                    load   = 1'b1;
                end
            end
            S_START: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = S_DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            S_DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shifter[7:1]};
                    bit_n   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7)
                        state_n = S_STOP;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: begin
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    // Held LF goes out ahead of anything queued, without a pop.
                    if (pend) begin
                        shift_n = 8'h0A;
                        pend_n  = 1'b0;
                        state_n = S_START;
                    end else if (count != '0) begin
                        do_pop = 1'b1;
                        load   = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
        endcase

        if (load) begin
            state_n = S_START;
            baud_n  = '0;
            if ((CRLF != 0) && (head == 8'h0A)) begin
                shift_n = 8'h0D;
                pend_n  = 1'b1;
            end else begin
                shift_n = head;
            end
        end

        do_push = print_wen && ((count != DEPTH_C) || do_pop);

        case ({do_push, do_pop})
            2'b10:   count_n = count + 1'b1;
            2'b01:   count_n = count - 1'b1;
            default: count_n = count;
        endcase

        case (state)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shifter[0];
            default: tx_n = 1'b1;
        endcase

        busy_n = (count_n != '0) || (state_n != S_IDLE) || pend_n;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= print_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            state     <= S_IDLE;
            baud      <= '0;
            bit_cnt   <= '0;
            shifter   <= '0;
            pend      <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_n;
            state     <= state_n;
            baud      <= baud_n;
            bit_cnt   <= bit_n;
            shifter   <= shift_n;
            pend      <= pend_n;
            tx        <= tx_n;
            busy      <= busy_n;
            fifo_full <= (count_n == DEPTH_C);
            if (print_wen && !do_push)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule
